mini_alu_mux: RTL and testbench
===============================

// Module: mini_alu_mux
// PURPOSE
//  Registered 8-function mini ALU: sel chooses one of eight arithmetic/logic results of ina/inb.
//  Result is captured in an output register. Small datapath leaf; no handshake.
//  Output valid one clock after operands/sel are applied.
// PARAMETERS
//  WIDTH  5  operand and result width in bits (supported range: 2..32)
// PORTS
//  clk   in   1      single clock; all state updates on rising edge
//  rst_n in   1      reset, synchronous, active-low
//  sel   in   3      operation select (encoding below)
//  ina   in   WIDTH  operand A
//  inb   in   WIDTH  operand B
//  out   out  WIDTH  registered result
// BEHAVIOUR
//  - Reset: at a rising clk edge with rst_n==0, out <= 0 (flags <= 0 when compiled in).
//    Reset overrides any operation in that cycle.
//  - Otherwise, every rising edge: out <= f(sel, ina, inb). Latency is 1 cycle; no enable.
//  - Op encoding, all results truncated to WIDTH (modulo 2^WIDTH):
//    000 ADD  ina+inb        001 SUB  ina-inb (two's complement wrap)
//    010 AND  ina&inb        011 OR   ina|inb
//    100 XOR  ina^inb        101 NOTA ~ina
//    110 SHL  ina<<1, LSB 0  111 SHR  ina>>1 logical, MSB 0
//  - Operands are unsigned.
//  - Overflow in ADD wraps silently. A negative SUB result wraps silently.
//  - sel changes every cycle without restriction. out always reflects the sel/operands
//    sampled at the previous edge.
//  - X/Z on inputs is not handled; the bench drives only known values.
// CONFIGURATION
//  MINI_ALU_FLAGS_EN defined: adds registered outputs carry (1b) and zero (1b),
//  updated in the same edge as out.
//    carry = ADD: bit WIDTH of ina+inb; SUB: borrow (ina<inb);
//            SHL: ina[WIDTH-1]; SHR: ina[0]; logic ops: 0.
//    zero  = (next out == 0).
//  MINI_ALU_FLAGS_EN undefined: flag ports and logic absent; out behaviour identical.
// STRUCTURE
//  - Package mini_alu_pkg: op_e enum (OP_ADD..OP_SHR, 3-bit) and default WIDTH constant.
//  - One sub-module, mini_alu_core: purely combinational f(sel,ina,inb) producing the
//    result and the pre-register carry.
//  - The top level holds only the output/flag registers and the reset.
// TESTING
//  WIDTH=5, ina=5'b10110, inb=5'b01011; reset first, then step sel 000..111, one value per cycle.
//  1 rst_n=0 for 2 cycles -> out==0 (carry=0, zero=0 if flags).
//    rst_n=1 with sel=000 -> next edge out==5'b00001, carry=1.
//  2 sel=001 -> out==5'b01011, carry=0.
//    Swap operands (a=01011, b=10110) -> out==5'b10101, carry=1.
//  3 sel=010/011/100 -> out==00010 / 11111 / 11101, carry=0.
//  4 sel=101 -> 01001. sel=110 -> 01100 (carry=1). sel=111 -> 01011 (carry=0).
//  5 sel=100 with ina=inb=10110 -> out==00000, zero=1.
//    Assert rst_n=0 in the same cycle as an ADD -> out==0 at that edge.
//  6 Randomized sel/ina/inb for 1000 cycles vs. reference model, checked one cycle later;
//    repeat once with MINI_ALU_FLAGS_EN undefined.

Source files
------------

// File: rtl/mini_alu_pkg.sv
// Shared definitions for the registered mini ALU.
// Optional flag outputs are compiled in with the MINI_ALU_FLAGS_EN macro.
package mini_alu_pkg;

  // Default operand/result width (supported range 2..32)
  localparam int MINI_ALU_WIDTH = 5;

  // Operation select encoding
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOTA = 3'b101,
    OP_SHL  = 3'b110,
    OP_SHR  = 3'b111
  } op_e;

endpackage

// File: rtl/mini_alu_core.sv
// Combinational mini ALU: result and pre-register carry for the selected op.
// All results are truncated to WIDTH; operands are unsigned.
module mini_alu_core
  import mini_alu_pkg::*;
#(
  parameter int WIDTH = MINI_ALU_WIDTH
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  op_e            op;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign op   = op_e'(sel);
  // One extra bit holds the ADD carry-out / SUB borrow (set exactly when ina < inb)
  assign sum  = {1'b0, ina} + {1'b0, inb};
  assign diff = {1'b0, ina} - {1'b0, inb};

  // Select the operation result and its carry
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD:  begin result = sum[WIDTH-1:0];  carry = sum[WIDTH];  end
      OP_SUB:  begin result = diff[WIDTH-1:0]; carry = diff[WIDTH]; end
      OP_AND:  result = ina & inb;
      OP_OR:   result = ina | inb;
      OP_XOR:  result = ina ^ inb;
      OP_NOTA: result = ~ina;
      OP_SHL:  begin result = {ina[WIDTH-2:0], 1'b0}; carry = ina[WIDTH-1]; end
      OP_SHR:  begin result = {1'b0, ina[WIDTH-1:1]}; carry = ina[0];       end
      default: begin result = '0; carry = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mini_alu_mux.sv
// Registered 8-function mini ALU. out reflects sel/ina/inb sampled at the
// previous rising edge. Define MINI_ALU_FLAGS_EN to add registered carry/zero.
module mini_alu_mux
  import mini_alu_pkg::*;
#(
  parameter int WIDTH = MINI_ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
`ifdef MINI_ALU_FLAGS_EN
  output logic             carry,
  output logic             zero,
`endif
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] core_result;
  logic             core_carry;

  mini_alu_core #(.WIDTH(WIDTH)) u_core (
    .sel    (sel),
    .ina    (ina),
    .inb    (inb),
    .result (core_result),
    .carry  (core_carry)
  );

  // Result register; synchronous reset wins over any operation
  always_ff @(posedge clk) begin
    if (!rst_n) out <= '0;
    else        out <= core_result;
  end

`ifdef MINI_ALU_FLAGS_EN
  // Flag registers, updated on the same edge as out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      carry <= core_carry;
      zero  <= (core_result == '0);
    end
  end
`else
  // Carry is produced by the shared core but has no consumer in this build
  logic carry_unused;
  assign carry_unused = core_carry;
`endif

endmodule

// File: tb/tb_mini_alu_mux.sv
// Self-checking bench for mini_alu_mux: directed steps followed by random
// operations compared against an arithmetic reference model.
module tb_mini_alu_mux;

  localparam int W = 5;
  localparam int M = 1 << W;

  logic         clk;
  logic         rst_n;
  logic [2:0]   sel;
  logic [W-1:0] ina;
  logic [W-1:0] inb;
  logic [W-1:0] out;
`ifdef MINI_ALU_FLAGS_EN
  logic         carry;
  logic         zero;
`endif

  int checks = 0;
  int errors = 0;

  // Scoreboard entry packs {zero, carry, out}
  logic [W+1:0] exp_q[$];

  mini_alu_mux #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sel   (sel),
    .ina   (ina),
    .inb   (inb),
`ifdef MINI_ALU_FLAGS_EN
    .carry (carry),
    .zero  (zero),
`endif
    .out   (out)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from the operation table, using plain integer arithmetic
  function automatic void ref_op(input int s, input int a, input int b,
                                 output int res, output int c);
    c = 0;
    case (s)
      0: begin res = (a + b) % M; c = ((a + b) >= M) ? 1 : 0; end
      1: begin res = (a - b + M) % M; c = (a < b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (M - 1) - a;
      6: begin res = (a * 2) % M; c = (a >= M / 2) ? 1 : 0; end
      default: begin res = a / 2; c = a % 2; end
    endcase
  endfunction

  function automatic logic [W+1:0] pack_exp(input int res, input int c, input int z);
    logic [W+1:0] e;
    e[W-1:0] = res[W-1:0];
    e[W]     = c[0];
    e[W+1]   = z[0];
    return e;
  endfunction

  // Driver: apply inputs, then sample 1 time unit after the next rising edge
  task automatic step(input logic r, input logic [2:0] s,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    rst_n = r;
    sel   = s;
    ina   = a;
    inb   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare outputs against one packed expectation
  task automatic check_all(input string tag, input logic [W+1:0] e);
    check({tag, ".out"}, 32'(out), 32'(e[W-1:0]));
`ifdef MINI_ALU_FLAGS_EN
    check({tag, ".carry"}, 32'(carry), 32'(e[W]));
    check({tag, ".zero"},  32'(zero),  32'(e[W+1]));
`endif
  endtask

  logic [W-1:0] a0;
  logic [W-1:0] b0;

  initial begin
    int res;
    int c;
    logic [W+1:0] e;
    logic r;
    logic [2:0] s;
    logic [W-1:0] a;
    logic [W-1:0] b;

    a0 = 5'b10110;
    b0 = 5'b01011;

    // Reset for two cycles
    step(1'b0, 3'b000, a0, b0);
    step(1'b0, 3'b000, a0, b0);
    check_all("reset", pack_exp(0, 0, 0));

    // Directed op walk with the reference operands
    step(1'b1, 3'b000, a0, b0); check_all("add",  pack_exp(5'b00001, 1, 0));
    step(1'b1, 3'b001, a0, b0); check_all("sub",  pack_exp(5'b01011, 0, 0));
    step(1'b1, 3'b001, b0, a0); check_all("sub_swap", pack_exp(5'b10101, 1, 0));
    step(1'b1, 3'b010, a0, b0); check_all("and",  pack_exp(5'b00010, 0, 0));
    step(1'b1, 3'b011, a0, b0); check_all("or",   pack_exp(5'b11111, 0, 0));
    step(1'b1, 3'b100, a0, b0); check_all("xor",  pack_exp(5'b11101, 0, 0));
    step(1'b1, 3'b101, a0, b0); check_all("nota", pack_exp(5'b01001, 0, 0));
    step(1'b1, 3'b110, a0, b0); check_all("shl",  pack_exp(5'b01100, 1, 0));
    step(1'b1, 3'b111, a0, b0); check_all("shr",  pack_exp(5'b01011, 0, 0));
    step(1'b1, 3'b100, a0, a0); check_all("xor_zero", pack_exp(0, 0, 1));
    // Reset asserted alongside an ADD that would carry
    step(1'b0, 3'b000, a0, b0); check_all("reset_add", pack_exp(0, 0, 0));

    // Random phase with occasional resets
    for (int i = 0; i < 1000; i++) begin
      r = ($urandom_range(0, 31) != 0);
      s = 3'($urandom_range(0, 7));
      a = W'($urandom_range(0, M - 1));
      b = W'($urandom_range(0, M - 1));
      if (r) begin
        ref_op(int'(s), int'(a), int'(b), res, c);
        exp_q.push_back(pack_exp(res, c, (res == 0) ? 1 : 0));
      end else begin
        exp_q.push_back(pack_exp(0, 0, 0));
      end
      step(r, s, a, b);
      e = exp_q.pop_front();
      check_all("rand", e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
